// File: rtl/spi_master_gen.sv
// Parametrised SPI master: valid/ready words in, SPI frames out on one of NUM_CS selects.
// Programmable SCLK divider, CPOL/CPHA and bit order; chip select is held across burst words.
module spi_master_gen #(
   parameter int DATA_W = 8,
   parameter int NUM_CS = 4,
   parameter int DIV_W  = 8,
   parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DIV_W-1:0]  cfg_div_i,
   input  logic              cfg_cpol_i,
   input  logic              cfg_cpha_i,
   input  logic              cfg_lsb_first_i,
   input  logic [CS_W-1:0]   cs_sel_i,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic              tx_last_i,
   input  logic              tx_valid_i,
   output logic              tx_ready_o,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              rx_valid_o,
   output logic              busy_o,
   output logic              sclk_o,
   output logic              mosi_o,
   input  logic              miso_i,
   output logic [NUM_CS-1:0] cs_n_o
);

   localparam int EDGES = 2 * DATA_W;
   localparam int EW    = $clog2(EDGES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_XFER, S_HOLD, S_GAP, S_WAIT
   } state_t;

   state_t              state_q;
   logic [DIV_W-1:0]    div_q;
   logic [DIV_W-1:0]    cnt_q;
   logic                cpha_q;
   logic                lsb_q;
   logic                last_q;
   logic [DATA_W-1:0]   tx_sh_q;
   logic [DATA_W-1:0]   rx_sh_q;
   logic [DATA_W-1:0]   rx_data_q;
   logic [EW-1:0]       edge_q;
   logic                sclk_q;
   logic                mosi_q;
   logic                rx_valid_q;
   logic [NUM_CS-1:0]   cs_n_q;

   logic                accept;
   logic                first_acc;
   logic                cpha_eff;
   logic                lsb_eff;
   logic [DIV_W-1:0]    div_eff;
   logic                first_bit_d;
   logic [DATA_W-1:0]   load_sh_d;
   logic                next_bit_d;
   logic [DATA_W-1:0]   tx_shift_d;
   logic [DATA_W-1:0]   rx_shift_d;
   logic                odd_edge;
   logic                last_edge;
   logic                cap_edge;
   logic                tick;
   logic [NUM_CS-1:0]   sel_dec;

   // One-hot select; an out-of-range index selects nothing.
   for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_sel
      assign sel_dec[gi] = (32'(cs_sel_i) == gi);
   end

   assign tx_ready_o = !rst && ((state_q == S_IDLE) || (state_q == S_WAIT));
   assign busy_o     = (state_q != S_IDLE);
   assign rx_data_o  = rx_data_q;
   assign rx_valid_o = rx_valid_q;
   assign sclk_o     = sclk_q;
   assign mosi_o     = mosi_q;
   assign cs_n_o     = cs_n_q;

   always_comb begin
      accept      = tx_valid_i && tx_ready_o;
      // The first word of a frame takes its settings straight from the cfg inputs.
      first_acc   = (state_q == S_IDLE);
      cpha_eff    = first_acc ? cfg_cpha_i      : cpha_q;
      lsb_eff     = first_acc ? cfg_lsb_first_i : lsb_q;
      div_eff     = first_acc ? cfg_div_i       : div_q;
      first_bit_d = lsb_eff ? tx_data_i[0] : tx_data_i[DATA_W-1];
      if (cpha_eff) begin
         load_sh_d = tx_data_i;
      end else begin
         load_sh_d = lsb_eff ? (tx_data_i >> 1) : (tx_data_i << 1);
      end
      next_bit_d  = lsb_q ? tx_sh_q[0] : tx_sh_q[DATA_W-1];
      tx_shift_d  = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
      rx_shift_d  = lsb_q ? {miso_i, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], miso_i};
      odd_edge    = ~edge_q[0];
      last_edge   = (edge_q == EW'(EDGES - 1));
      cap_edge    = odd_edge ^ cpha_q;
      tick        = (cnt_q == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         div_q      <= '0;
         cnt_q      <= '0;
         cpha_q     <= 1'b0;
         lsb_q      <= 1'b0;
         last_q     <= 1'b0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         edge_q     <= '0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         cs_n_q     <= '1;
      end else begin
         rx_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               sclk_q <= cfg_cpol_i;
               mosi_q <= 1'b0;
               cs_n_q <= '1;
               if (accept) begin
                  div_q  <= cfg_div_i;
                  cpha_q <= cfg_cpha_i;
                  lsb_q  <= cfg_lsb_first_i;
                  cs_n_q <= ~sel_dec;
               end
            end
            S_SETUP: begin
               if (tick) begin
                  state_q <= S_XFER;
                  cnt_q   <= div_q;
               end else begin
                  cnt_q <= cnt_q - DIV_W'(1);
               end
            end
            S_XFER: begin
               if (tick) begin
                  cnt_q  <= div_q;
                  sclk_q <= ~sclk_q;
                  edge_q <= edge_q + EW'(1);
                  if (cap_edge) begin
                     rx_sh_q <= rx_shift_d;
                  end else if (!last_edge) begin
                     mosi_q  <= next_bit_d;
                     tx_sh_q <= tx_shift_d;
                  end
                  if (last_edge) begin
                     rx_valid_q <= 1'b1;
                     rx_data_q  <= cap_edge ? rx_shift_d : rx_sh_q;
                     state_q    <= last_q ? S_HOLD : S_WAIT;
                  end
               end else begin
                  cnt_q <= cnt_q - DIV_W'(1);
               end
            end
            S_HOLD: begin
               if (tick) begin
                  state_q <= S_GAP;
                  cs_n_q  <= '1;
                  cnt_q   <= div_q;
               end else begin
                  cnt_q <= cnt_q - DIV_W'(1);
               end
            end
            S_GAP: begin
               if (tick) begin
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - DIV_W'(1);
               end
            end
            S_WAIT: begin
               // sclk already rests at cpol after the final edge; nothing toggles here.
            end
            default: state_q <= S_IDLE;
         endcase

         if (accept) begin
            state_q <= S_SETUP;
            cnt_q   <= div_eff;
            edge_q  <= '0;
            last_q  <= tx_last_i;
            tx_sh_q <= load_sh_d;
            if (!cpha_eff) begin
               mosi_q <= first_bit_d;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_master_gen.sv
// Directed bench for spi_master_gen: table of single-word frames plus burst and async-reset sequences.
module tb_spi_master_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  cfg_div = 8'd0;
   logic        cfg_cpol = 1'b1;
   logic        cfg_cpha = 1'b0;
   logic        cfg_lsb = 1'b0;
   logic [2:0]  cs_sel = 3'd0;
   logic [7:0]  tx_data = 8'd0;
   logic        tx_last = 1'b0;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        busy;
   logic        sclk;
   logic        mosi;
   logic        miso;
   logic [3:0]  cs_n;

   logic        loop_en = 1'b0;
   logic [7:0]  slv_word = 8'd0;
   logic        slv_bit;
   logic        f_cpol = 1'b0;
   logic        f_cpha = 1'b0;
   logic        f_lsb = 1'b0;
   logic        mon_en = 1'b0;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   assign miso = loop_en ? mosi : slv_bit;

   spi_master_gen #(
      .DATA_W(8), .NUM_CS(4), .DIV_W(8), .CS_W(3)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_div_i(cfg_div), .cfg_cpol_i(cfg_cpol), .cfg_cpha_i(cfg_cpha),
      .cfg_lsb_first_i(cfg_lsb), .cs_sel_i(cs_sel),
      .tx_data_i(tx_data), .tx_last_i(tx_last), .tx_valid_i(tx_valid),
      .tx_ready_o(tx_ready), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
      .busy_o(busy), .sclk_o(sclk), .mosi_o(mosi), .miso_i(miso), .cs_n_o(cs_n)
   );

   // Bus monitor and slave model, sampled on the falling clock edge.
   logic        mon_en_q = 1'b0;
   logic        sclk_prev = 1'b0;
   logic        mosi_prev = 1'b0;
   logic [3:0]  cs_prev = 4'hF;
   int          busy_cyc, wait_cyc, wait_bad, cs_low, cs_chg, cs_rise;
   int          rxv_cnt, toggles, rises, cap_bad, slv_idx;
   logic [3:0]  cs_val;
   logic [31:0] mosi_word;
   logic [7:0]  rx_log [4];

   initial slv_bit = 1'b0;

   function automatic logic slv_seq(input int i);
      return f_lsb ? slv_word[i] : slv_word[7-i];
   endfunction

   always @(negedge clk) begin
      mon_en_q  <= mon_en;
      sclk_prev <= sclk;
      mosi_prev <= mosi;
      cs_prev   <= cs_n;
      if (mon_en && !mon_en_q) begin
         busy_cyc <= 0; wait_cyc <= 0; wait_bad <= 0; cs_low <= 0; cs_chg <= 0;
         cs_rise <= 0; rxv_cnt <= 0; toggles <= 0; rises <= 0; cap_bad <= 0;
         cs_val <= 4'hF; mosi_word <= '0;
         for (int k = 0; k < 4; k++) rx_log[k] <= 8'h00;
         slv_idx <= f_cpha ? 0 : 1;
         slv_bit <= f_cpha ? 1'b0 : slv_seq(0);
      end else if (mon_en) begin
         if (busy) busy_cyc <= busy_cyc + 1;
         if (busy && tx_ready) begin
            wait_cyc <= wait_cyc + 1;
            if (sclk != f_cpol) wait_bad <= wait_bad + 1;
         end
         if (cs_n != 4'hF) begin
            cs_low <= cs_low + 1;
            cs_val <= cs_n;
            if (cs_prev != 4'hF && cs_prev != cs_n) cs_chg <= cs_chg + 1;
         end else if (cs_prev != 4'hF) begin
            cs_rise <= cs_rise + 1;
         end
         if (rx_valid) begin
            if (rxv_cnt < 4) rx_log[rxv_cnt] <= rx_data;
            rxv_cnt <= rxv_cnt + 1;
         end
         if (sclk != sclk_prev) begin
            toggles <= toggles + 1;
            if (sclk) rises <= rises + 1;
            if ((sclk != f_cpol) ^ f_cpha) begin
               mosi_word <= {mosi_word[30:0], mosi};
               if (mosi != mosi_prev) cap_bad <= cap_bad + 1;
            end else if (slv_idx < 8) begin
               slv_bit <= slv_seq(slv_idx);
               slv_idx <= slv_idx + 1;
            end
         end
      end
   end

   typedef struct {
      logic [7:0] div;
      logic       cpol;
      logic       cpha;
      logic       lsb;
      logic [2:0] cs;
      logic [7:0] tx;
      logic       loopb;
      logic [7:0] slv;
      logic [7:0] exp_rx;
      logic [7:0] exp_mosi;
      logic [3:0] exp_cs;
      int         exp_cs_low;
      int         exp_busy;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
      end else begin
         $display("ok   %s = %0h", nm, got);
      end
   endtask

   task automatic send_word(input logic [7:0] d, input logic last);
      int n;
      n = 0;
      tx_data  = d;
      tx_last  = last;
      tx_valid = 1'b1;
      while (!tx_ready && n < 10000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 10000) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: got no tx_ready, expected tx_ready=1");
      end
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 10000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 10000) begin
         n_checks++;
         n_fail++;
         $display("FAIL idle_timeout: got busy=1, expected busy=0");
      end
   endtask

   task automatic set_frame(input logic [7:0] div, input logic cpol, input logic cpha,
                            input logic lsb, input logic [2:0] cs, input logic lp,
                            input logic [7:0] slv);
      cfg_div = div; cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb = lsb; cs_sel = cs;
      f_cpol = cpol; f_cpha = cpha; f_lsb = lsb;
      loop_en = lp; slv_word = slv;
      repeat (3) @(negedge clk);
      mon_en = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic run_frame(input int idx);
      vec_t v;
      v = vecs[idx];
      set_frame(v.div, v.cpol, v.cpha, v.lsb, v.cs, v.loopb, v.slv);
      send_word(v.tx, 1'b1);
      wait_idle();
      @(negedge clk);
      mon_en = 1'b0;
      @(negedge clk);
      $display("vec %0d: tx=%0h rx=%0h cs=%0h cs_low=%0d busy=%0d", idx, v.tx, rx_log[0], cs_val, cs_low, busy_cyc);
      check($sformatf("v%0d rx_data", idx), 32'(rx_log[0]), 32'(v.exp_rx));
      check($sformatf("v%0d rx_valid_pulses", idx), rxv_cnt, 1);
      check($sformatf("v%0d mosi_bits", idx), mosi_word, 32'(v.exp_mosi));
      check($sformatf("v%0d cs_n_low_value", idx), 32'(cs_val), 32'(v.exp_cs));
      check($sformatf("v%0d cs_low_cycles", idx), cs_low, v.exp_cs_low);
      check($sformatf("v%0d busy_cycles", idx), busy_cyc, v.exp_busy);
      check($sformatf("v%0d sclk_toggles", idx), toggles, 16);
      check($sformatf("v%0d sclk_rises", idx), rises, 8);
      check($sformatf("v%0d mosi_change_at_capture", idx), cap_bad, 0);
      check($sformatf("v%0d sclk_idle", idx), 32'(sclk), 32'(v.cpol));
   endtask

   initial begin
      //          div    cpol  cpha  lsb   cs    tx     lp    slv    rx     mosi   cs    low   busy
      vecs[0] = '{8'd1,  1'b0, 1'b0, 1'b0, 3'd2, 8'hA5, 1'b0, 8'h3C, 8'h3C, 8'hA5, 4'hB, 36,   38};
      vecs[1] = '{8'd0,  1'b0, 1'b0, 1'b0, 3'd0, 8'h96, 1'b1, 8'h00, 8'h96, 8'h96, 4'hE, 18,   19};
      vecs[2] = '{8'd0,  1'b0, 1'b1, 1'b0, 3'd1, 8'h96, 1'b1, 8'h00, 8'h96, 8'h96, 4'hD, 18,   19};
      vecs[3] = '{8'd0,  1'b1, 1'b0, 1'b0, 3'd3, 8'h96, 1'b1, 8'h00, 8'h96, 8'h96, 4'h7, 18,   19};
      vecs[4] = '{8'd0,  1'b1, 1'b1, 1'b0, 3'd0, 8'h96, 1'b1, 8'h00, 8'h96, 8'h96, 4'hE, 18,   19};
      vecs[5] = '{8'd0,  1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 1'b1, 8'h00, 8'h01, 8'h80, 4'hE, 18,   19};
      vecs[6] = '{8'd0,  1'b0, 1'b0, 1'b0, 3'd5, 8'h5A, 1'b0, 8'hC3, 8'hC3, 8'h5A, 4'hF, 0,    19};
      vecs[7] = '{8'd3,  1'b1, 1'b1, 1'b1, 3'd2, 8'hC8, 1'b0, 8'h1E, 8'h1E, 8'h13, 4'hB, 72,   76};
      vecs[8] = '{8'hFF, 1'b0, 1'b0, 1'b0, 3'd1, 8'h03, 1'b1, 8'h00, 8'h03, 8'h03, 4'hD, 4608, 4864};

      // Power-up reset values, then first cycle after release.
      repeat (3) @(negedge clk);
      check("rst cs_n", 32'(cs_n), 32'hF);
      check("rst sclk", 32'(sclk), 0);
      check("rst mosi", 32'(mosi), 0);
      check("rst rx_data", 32'(rx_data), 0);
      check("rst rx_valid", 32'(rx_valid), 0);
      check("rst tx_ready", 32'(tx_ready), 0);
      check("rst busy", 32'(busy), 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst tx_ready", 32'(tx_ready), 1);
      check("post_rst sclk_cpol", 32'(sclk), 1);
      cfg_cpol = 1'b0;

      for (int i = 0; i < 9; i++) run_frame(i);

      // Burst of three words; cfg and cs_sel changes mid-frame must be ignored.
      set_frame(8'd0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 8'h00);
      send_word(8'h01, 1'b0);
      cs_sel = 3'd3; cfg_cpol = 1'b1; cfg_lsb = 1'b1; cfg_div = 8'd5; cfg_cpha = 1'b1;
      begin
         int n;
         n = 0;
         while (!(busy && tx_ready) && n < 1000) begin
            @(negedge clk);
            n++;
         end
         check("burst reached_wait", 32'(n < 1000), 1);
      end
      repeat (10) @(negedge clk);
      send_word(8'h80, 1'b0);
      send_word(8'hFF, 1'b1);
      cs_sel = 3'd1; cfg_cpol = 1'b0; cfg_lsb = 1'b0; cfg_div = 8'd0; cfg_cpha = 1'b0;
      wait_idle();
      @(negedge clk);
      mon_en = 1'b0;
      @(negedge clk);
      $display("burst: rx=%0h,%0h,%0h wait=%0d cs_low=%0d", rx_log[0], rx_log[1], rx_log[2], wait_cyc, cs_low);
      check("burst rx_valid_pulses", rxv_cnt, 3);
      check("burst rx0", 32'(rx_log[0]), 32'h01);
      check("burst rx1", 32'(rx_log[1]), 32'h80);
      check("burst rx2", 32'(rx_log[2]), 32'hFF);
      check("burst mosi_bits", mosi_word, 32'h0180FF);
      check("burst cs_rises", cs_rise, 1);
      check("burst cs_changes", cs_chg, 0);
      check("burst cs_n_low_value", 32'(cs_val), 32'hD);
      check("burst sclk_toggles", toggles, 48);
      check("burst sclk_moved_in_wait", wait_bad, 0);
      check("burst wait_ge_11", 32'(wait_cyc >= 11), 1);
      check("burst cs_low_cycles", cs_low, 18 + 34 + wait_cyc);

      // Asynchronous reset in the middle of a word.
      set_frame(8'd1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00);
      send_word(8'hC3, 1'b1);
      repeat (8) @(negedge clk);
      check("abort in_flight_cs", 32'(cs_n), 32'hE);
      #2 rst = 1'b1;
      #1;
      check("abort cs_n_async", 32'(cs_n), 32'hF);
      check("abort busy", 32'(busy), 0);
      check("abort tx_ready", 32'(tx_ready), 0);
      check("abort sclk", 32'(sclk), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("abort release tx_ready", 32'(tx_ready), 1);
      check("abort release sclk_cpol", 32'(sclk), 1);
      repeat (20) @(negedge clk);
      check("abort rx_valid_pulses", rxv_cnt, 0);
      mon_en = 1'b0;
      @(negedge clk);
      run_frame(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
